// File: rtl/con_eval_pkg.sv
// Shared constants, mode encoding and helpers for the con-class evaluation pipeline.
package con_eval_pkg;

  // Width of one input vector and the position of each named literal in it.
  localparam int VEC_W = 7;
  localparam int A_IDX = 0;
  localparam int B_IDX = 1;
  localparam int C_IDX = 2;
  localparam int D_IDX = 3;
  localparam int F_IDX = 4;
  localparam int G_IDX = 5;
  localparam int H_IDX = 6;

  // Per-beat output mode; the unused encoding 2'b11 behaves like MODE_NORM.
  typedef enum logic [1:0] {
    MODE_NORM   = 2'b00,
    MODE_INV    = 2'b01,
    MODE_STICKY = 2'b10
  } mode_e;

  // Number of ones in a word of up to 32 lanes.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/con_eval_lane.sv
// One evaluation channel: the fixed f0/f1 sum-of-products pair on a 7-bit vector.
module con_eval_lane
  import con_eval_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             f0,
  output logic             f1
);

  logic a, b, c, d, f, g, h;

  assign a = vec[A_IDX];
  assign b = vec[B_IDX];
  assign c = vec[C_IDX];
  assign d = vec[D_IDX];
  assign f = vec[F_IDX];
  assign g = vec[G_IDX];
  assign h = vec[H_IDX];

  assign f0 = (a & b) | (~b & ~c & d) | (c & d & f) | (b & h & ~f);
  assign f1 = (~a & ~b) | (~a & f) | (a & b & ~f) | (~f & ~g) | (~b & ~d & f);

endmodule

// File: rtl/con_eval_pipe.sv
// Elastic LANES-wide f0/f1 evaluator with per-beat output modes and
// saturating hit counters. Functions are computed ahead of stage 1; the mode
// is applied when a beat is loaded into the last (output) stage.
module con_eval_pipe
  import con_eval_pkg::*;
#(
  parameter int LANES = 4,
  parameter int PIPE  = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [VEC_W*LANES-1:0] in_vec,
  input  logic [1:0]             in_mode,
  input  logic                   clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       out_f0,
  output logic [LANES-1:0]       out_f1,
  output logic [CNT_W-1:0]       f0_cnt,
  output logic [CNT_W-1:0]       f1_cnt,
  output logic                   cnt_sat
);

  genvar gi;

  if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
    $error("con_eval_pipe: PIPE must be 1 or 2");
  end

  // ---------------- lane functions ----------------
  logic [LANES-1:0] raw_f0;
  logic [LANES-1:0] raw_f1;

  for (gi = 0; gi < LANES; gi++) begin : g_lane
    con_eval_lane u_lane (
      .vec (in_vec[gi*VEC_W +: VEC_W]),
      .f0  (raw_f0[gi]),
      .f1  (raw_f1[gi])
    );
  end

  // ---------------- elastic stages ----------------
  logic [PIPE:1]    s_valid;
  logic [1:0]       s_mode [PIPE:1];
  logic [LANES-1:0] s_f0   [PIPE:1];
  logic [LANES-1:0] s_f1   [PIPE:1];
  logic [PIPE:1]    stage_ready;

  // A stage can take a new beat when empty or when its contents move on;
  // the ready chain is resolved from the output backwards.
  always_comb begin
    logic rdy;
    stage_ready = '0;
    rdy = out_ready;
    for (int k = PIPE; k >= 1; k--) begin
      stage_ready[k] = ~s_valid[k] | rdy;
      rdy = stage_ready[k];
    end
  end

  assign in_ready = stage_ready[1];

  for (gi = 1; gi <= PIPE; gi++) begin : g_stage
    logic             up_v;
    logic [1:0]       up_m;
    logic [LANES-1:0] up_f0;
    logic [LANES-1:0] up_f1;
    logic             v_reg;
    logic [1:0]       m_reg;
    logic [LANES-1:0] f0_reg;
    logic [LANES-1:0] f1_reg;

    if (gi == 1) begin : g_src_in
      assign up_v  = in_valid;
      assign up_m  = in_mode;
      assign up_f0 = raw_f0;
      assign up_f1 = raw_f1;
    end else begin : g_src_stage
      assign up_v  = s_valid[gi-1];
      assign up_m  = s_mode[gi-1];
      assign up_f0 = s_f0[gi-1];
      assign up_f1 = s_f1[gi-1];
    end

    // Stage register: takes the upstream beat (or a bubble) whenever it may load.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_reg  <= 1'b0;
        m_reg  <= '0;
        f0_reg <= '0;
        f1_reg <= '0;
      end else if (stage_ready[gi]) begin
        v_reg <= up_v;
        if (up_v) begin
          m_reg  <= up_m;
          f0_reg <= up_f0;
          f1_reg <= up_f1;
        end
      end
    end

    assign s_valid[gi] = v_reg;
    assign s_mode[gi]  = m_reg;
    assign s_f0[gi]    = f0_reg;
    assign s_f1[gi]    = f1_reg;
  end

  // Beat arriving at the output stage this cycle.
  logic             ld_v;
  logic [1:0]       ld_m;
  logic [LANES-1:0] ld_f0;
  logic [LANES-1:0] ld_f1;

  if (PIPE == 1) begin : g_ld_in
    assign ld_v  = in_valid;
    assign ld_m  = in_mode;
    assign ld_f0 = raw_f0;
    assign ld_f1 = raw_f1;
  end else begin : g_ld_stage
    assign ld_v  = s_valid[PIPE-1];
    assign ld_m  = s_mode[PIPE-1];
    assign ld_f0 = s_f0[PIPE-1];
    assign ld_f1 = s_f1[PIPE-1];
  end

  logic out_fire;
  assign out_valid = s_valid[PIPE];
  assign out_fire  = out_valid & out_ready;

  // ---------------- sticky state ----------------
  logic [LANES-1:0] sticky_f0_reg, sticky_f1_reg;
  logic [LANES-1:0] sticky_f0_next, sticky_f1_next;

  // Clear first, then fold in the raw value of an accepted sticky-mode beat.
  always_comb begin
    sticky_f0_next = clr ? '0 : sticky_f0_reg;
    sticky_f1_next = clr ? '0 : sticky_f1_reg;
    if (out_fire && s_mode[PIPE] == MODE_STICKY) begin
      sticky_f0_next = sticky_f0_next | s_f0[PIPE];
      sticky_f1_next = sticky_f1_next | s_f1[PIPE];
    end
  end

  // Sticky registers hold the OR of accepted sticky-mode beats since clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_f0_reg <= '0;
      sticky_f1_reg <= '0;
    end else begin
      sticky_f0_reg <= sticky_f0_next;
      sticky_f1_reg <= sticky_f1_next;
    end
  end

  // ---------------- output mode ----------------
  logic [LANES-1:0] mode_f0, mode_f1;
  logic [LANES-1:0] out_f0_reg, out_f1_reg;

  // Mode transform of the loading beat; sticky uses the post-edge sticky value
  // so a beat leaving in the same cycle is already folded in.
  always_comb begin
    mode_f0 = ld_f0;
    mode_f1 = ld_f1;
    case (ld_m)
      MODE_INV: begin
        mode_f0 = ~ld_f0;
        mode_f1 = ~ld_f1;
      end
      MODE_STICKY: begin
        mode_f0 = sticky_f0_next | ld_f0;
        mode_f1 = sticky_f1_next | ld_f1;
      end
      default: begin
        mode_f0 = ld_f0;
        mode_f1 = ld_f1;
      end
    endcase
  end

  // Presented results load together with the last stage and hold under stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_f0_reg <= '0;
      out_f1_reg <= '0;
    end else if (stage_ready[PIPE] && ld_v) begin
      out_f0_reg <= mode_f0;
      out_f1_reg <= mode_f1;
    end
  end

  assign out_f0 = out_f0_reg;
  assign out_f1 = out_f1_reg;

  // ---------------- hit counters ----------------
  logic [CNT_W-1:0] cnt0_reg, cnt1_reg, cnt0_next, cnt1_next;
  logic [CNT_W-1:0] base0, base1;
  logic [CNT_W:0]   sum0, sum1;
  logic             sat_reg, sat_next;

  // Add presented popcounts on accepted beats, clamping at all-ones.
  always_comb begin
    base0 = clr ? '0 : cnt0_reg;
    base1 = clr ? '0 : cnt1_reg;
    sum0  = {1'b0, base0} + (CNT_W+1)'(popcount(32'(out_f0_reg)));
    sum1  = {1'b0, base1} + (CNT_W+1)'(popcount(32'(out_f1_reg)));
    cnt0_next = base0;
    cnt1_next = base1;
    sat_next  = clr ? 1'b0 : sat_reg;
    if (out_fire) begin
      cnt0_next = sum0[CNT_W] ? '1 : sum0[CNT_W-1:0];
      cnt1_next = sum1[CNT_W] ? '1 : sum1[CNT_W-1:0];
      sat_next  = sat_next | sum0[CNT_W] | sum1[CNT_W];
    end
  end

  // Counter and saturation-flag state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_reg <= '0;
      cnt1_reg <= '0;
      sat_reg  <= 1'b0;
    end else begin
      cnt0_reg <= cnt0_next;
      cnt1_reg <= cnt1_next;
      sat_reg  <= sat_next;
    end
  end

  assign f0_cnt  = cnt0_reg;
  assign f1_cnt  = cnt1_reg;
  assign cnt_sat = sat_reg;

endmodule
